// File: rtl/sram_port_init_if.sv
// Request/response handshake bundle for the SRAM port controller.
// The master issues requests and consumes read responses; the slave serves them.
interface sram_port_init_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [9:0]  req_addr;
    logic [17:0] req_wdata;
    logic [17:0] req_wmsk;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [17:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmsk, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmsk, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_port_init.sv
// SRAM port controller: registered SRAM pins, 2-cycle reads, 2-deep response FIFO.
// Define SRAM_PORT_INIT_CLEAR_EN to zero the whole array after every reset.
module sram_port_init (
    input  logic               clk,
    input  logic               rst_n,
    sram_port_init_if.slave    bus,
    output logic               busy,
    output logic               sram_cen,
    output logic               sram_wen,
    output logic [9:0]         sram_addr,
    output logic [17:0]        sram_wmsk,
    output logic [17:0]        sram_wdata,
    input  logic [17:0]        sram_rdata
);

`ifdef SRAM_PORT_INIT_CLEAR_EN
    typedef enum logic [1:0] {ST_INIT, ST_CLEAR, ST_RUN} state_t;
`else
    typedef enum logic [1:0] {ST_INIT, ST_RUN} state_t;
`endif

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_cen;
    logic        r_wen;
    logic [9:0]  r_addr;
    logic [17:0] r_wmsk;
    logic [17:0] r_wdata;
    logic        w_cen_nxt;
    logic        w_wen_nxt;
    logic [9:0]  w_addr_nxt;
    logic [17:0] w_wmsk_nxt;
    logic [17:0] w_wdata_nxt;

    // p1: read command on the pins, p2: SRAM has sampled, data lands next edge
    logic        r_rd_p1;
    logic        r_rd_p2;
    logic        w_rd_nxt;

    logic [17:0] r_buf [2];
    logic        r_wp;
    logic        r_rp;
    logic [1:0]  r_cnt;
    logic [1:0]  w_occ;
    logic        w_acc;
    logic        w_push;
    logic        w_pop;

`ifdef SRAM_PORT_INIT_CLEAR_EN
    logic [9:0]  r_clr;
    logic [9:0]  w_clr_nxt;
`endif

    assign w_occ         = r_cnt + {1'b0, r_rd_p1} + {1'b0, r_rd_p2};
    assign bus.req_ready = (r_state == ST_RUN) && (w_occ < 2'd2);
    assign w_acc         = bus.req_valid && bus.req_ready;
    assign w_push        = r_rd_p2;
    assign bus.rsp_valid = (r_cnt != 2'd0);
    assign w_pop         = bus.rsp_valid && bus.rsp_ready;
    assign bus.rsp_rdata = r_buf[r_rp];

`ifdef SRAM_PORT_INIT_CLEAR_EN
    assign busy = (r_state == ST_CLEAR);
`else
    assign busy = 1'b0;
`endif

    assign sram_cen   = r_cen;
    assign sram_wen   = r_wen;
    assign sram_addr  = r_addr;
    assign sram_wmsk  = r_wmsk;
    assign sram_wdata = r_wdata;

    always_comb begin
        w_state_nxt = r_state;
        w_cen_nxt   = 1'b1;
        w_wen_nxt   = 1'b1;
        w_addr_nxt  = 10'd0;
        w_wmsk_nxt  = '1;
        w_wdata_nxt = 18'd0;
        w_rd_nxt    = 1'b0;
`ifdef SRAM_PORT_INIT_CLEAR_EN
        w_clr_nxt   = r_clr;
`endif
        unique case (r_state)
            ST_INIT: begin
`ifdef SRAM_PORT_INIT_CLEAR_EN
                w_state_nxt = ST_CLEAR;
`else
                w_state_nxt = ST_RUN;
`endif
            end
`ifdef SRAM_PORT_INIT_CLEAR_EN
            ST_CLEAR: begin
                w_wen_nxt  = 1'b0;
                w_addr_nxt = r_clr;
                w_wmsk_nxt = 18'd0;
                w_clr_nxt  = r_clr + 10'd1;
                if (r_clr == 10'd1023)
                    w_state_nxt = ST_RUN;
            end
`endif
            ST_RUN: begin
                if (w_acc) begin
                    w_addr_nxt = bus.req_addr;
                    if (bus.req_we) begin
                        w_wen_nxt   = 1'b0;
                        w_wmsk_nxt  = bus.req_wmsk;
                        w_wdata_nxt = bus.req_wdata;
                    end else begin
                        w_cen_nxt = 1'b0;
                        w_rd_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_cen   <= 1'b1;
            r_wen   <= 1'b1;
            r_addr  <= 10'd0;
            r_wmsk  <= '1;
            r_wdata <= 18'd0;
            r_rd_p1 <= 1'b0;
            r_rd_p2 <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cen   <= w_cen_nxt;
            r_wen   <= w_wen_nxt;
            r_addr  <= w_addr_nxt;
            r_wmsk  <= w_wmsk_nxt;
            r_wdata <= w_wdata_nxt;
            r_rd_p1 <= w_rd_nxt;
            r_rd_p2 <= r_rd_p1;
        end
    end

`ifdef SRAM_PORT_INIT_CLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_clr <= 10'd0;
        else
            r_clr <= w_clr_nxt;
    end
`endif

    // occ gating on req_ready guarantees a push never meets a full buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf[0] <= 18'd0;
            r_buf[1] <= 18'd0;
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_buf[r_wp] <= sram_rdata;
                r_wp        <= ~r_wp;
            end
            if (w_pop)
                r_rp <= ~r_rp;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_sram_port_init.sv
// Scoreboard bench for sram_port_init with a behavioural single-port SRAM.
// Expected read data is queued at accept; a negedge monitor checks responses.
module tb_sram_port_init;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic        sram_cen;
    logic        sram_wen;
    logic [9:0]  sram_addr;
    logic [17:0] sram_wmsk;
    logic [17:0] sram_wdata;
    logic [17:0] sram_rdata;

    logic [17:0] mem [1024] = '{default: 18'h2AAAA};
    logic [17:0] exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    sram_port_init_if bus ();

    sram_port_init dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .busy       (busy),
        .sram_cen   (sram_cen),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wmsk  (sram_wmsk),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // SRAM: wmsk bit 1 keeps the old bit, 0 takes wdata
    always @(posedge clk) begin
        if (!sram_cen)
            sram_rdata <= mem[sram_addr];
        if (!sram_wen)
            mem[sram_addr] <= (mem[sram_addr] & sram_wmsk) |
                              (sram_wdata & ~sram_wmsk);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid) begin
            if (exp_q.size() == 0)
                chk("rsp_unexpected", 32'd1, 32'd0);
            else if (bus.rsp_ready)
                chk("rsp_data", {14'd0, bus.rsp_rdata}, {14'd0, exp_q.pop_front()});
            else
                chk("rsp_hold", {14'd0, bus.rsp_rdata}, {14'd0, exp_q[0]});
        end
    end

    task automatic send(input logic we, input logic [9:0] a,
                        input logic [17:0] d, input logic [17:0] m,
                        input logic [17:0] e, input bit push);
        int n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wmsk  = m;
        @(negedge clk);
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready)
            chk("accept_timeout", 32'd0, 32'd1);
        else if (!we && push)
            exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 30 && exp_q.size() != 0; c++)
            @(negedge clk);
        chk("drain", exp_q.size(), 32'd0);
    endtask

    logic [9:0]  ra [4] = '{10'h010, 10'h011, 10'h012, 10'h013};
    logic [17:0] rd [4] = '{18'h11111, 18'h22222, 18'h33333, 18'h04444};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        int bad;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 10'd0;
        bus.req_wdata = 18'd0;
        bus.req_wmsk  = 18'd0;
        bus.rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cen", sram_cen, 1);
        chk("rst_wen", sram_wen, 1);
        chk("rst_addr", sram_addr, 0);
        chk("rst_wmsk", sram_wmsk, 18'h3FFFF);
        chk("rst_wdata", sram_wdata, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);

`ifdef SRAM_PORT_INIT_CLEAR_EN
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (!busy || bus.req_ready)
                bad++;
        end
        chk("clear_busy_window", bad, 0);
        @(negedge clk);
        chk("clear_done_busy", busy, 0);
        chk("clear_done_ready", bus.req_ready, 1);
        @(posedge clk);
        #1;
        send(1'b0, 10'h3FF, 18'd0, 18'd0, 18'h00000, 1'b1);
        drain();
`else
        @(negedge clk);
        chk("start_ready", bus.req_ready, 1);
        chk("start_busy", busy, 0);
        @(posedge clk);
        #1;
`endif

        // write then back-to-back read, with latency check
        send(1'b1, 10'h005, 18'h3FFFF, 18'h00000, 18'd0, 1'b0);
        send(1'b0, 10'h005, 18'd0, 18'd0, 18'h3FFFF, 1'b1);
        @(negedge clk);
        chk("rd_cen", sram_cen, 0);
        chk("rd_addr", sram_addr, 10'h005);
        chk("lat_e1", bus.rsp_valid, 0);
        @(negedge clk);
        chk("lat_e2", bus.rsp_valid, 0);
        @(negedge clk);
        chk("lat_e3", bus.rsp_valid, 1);
        drain();

        send(1'b1, 10'h005, 18'h00000, 18'h3FF00, 18'd0, 1'b0);
        send(1'b0, 10'h005, 18'd0, 18'd0, 18'h3FF00, 1'b1);
        send(1'b1, 10'h2A5, 18'h12345, 18'h00000, 18'd0, 1'b0);
        send(1'b1, 10'h2A5, 18'h3FFFF, 18'h000FF, 18'd0, 1'b0);
        send(1'b1, 10'h3FF, 18'h00001, 18'h00000, 18'd0, 1'b0);
        send(1'b1, 10'h000, 18'h20000, 18'h00000, 18'd0, 1'b0);
        send(1'b0, 10'h2A5, 18'd0, 18'd0, 18'h3FF45, 1'b1);
        send(1'b0, 10'h3FF, 18'd0, 18'd0, 18'h00001, 1'b1);
        send(1'b0, 10'h000, 18'd0, 18'd0, 18'h20000, 1'b1);
        drain();

        // backpressure: only two reads may be outstanding
        for (int k = 0; k < 4; k++)
            send(1'b1, ra[k], rd[k], 18'h00000, 18'd0, 1'b0);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            bus.req_addr = ra[acc];
            @(negedge clk);
            if (bus.req_ready) begin
                exp_q.push_back(rd[acc]);
                acc++;
            end
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", acc, 2);
        chk("bp_ready_low", bus.req_ready, 0);
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 20 && acc < 4; c++) begin
            bus.req_addr = ra[acc];
            @(negedge clk);
            if (bus.req_ready) begin
                exp_q.push_back(rd[acc]);
                acc++;
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        chk("bp_all_accepted", acc, 4);
        drain();

        // reset one cycle after a read accept kills the read
        send(1'b0, 10'h010, 18'd0, 18'd0, 18'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort_cen", sram_cen, 1);
        chk("abort_wen", sram_wen, 1);
        chk("abort_ready", bus.req_ready, 0);
        chk("abort_rsp_valid", bus.rsp_valid, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.rsp_valid)
                bad++;
        end
        chk("abort_no_rsp", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
